ra_pq_kv_demux: RTL and testbench
=================================

Name: ra_pq_kv_demux

Overview:
- Buffered 1-to-2 steering block for kv_t items (pq_pkg). It is the splitting counterpart of the 2-1 kv mux.
- Takes one valid/ready kv stream and routes each item to output channel 0 or 1 according to a per-item select.
- Each channel has its own FIFO, so a stalled priority-queue bank does not block traffic to the other bank.
- Sits between the PQ front end and two register-array PQ banks.

Parameters:
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2.
- CW, $clog2(DEPTH+1), width of the occupancy count outputs (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of both channels.
- in_valid  input  1  an input item is presented.
- in_ready  output  1  the input item is accepted this cycle.
- in_kv  input  kv_t  input key-value item.
- in_sel  input  1  destination channel: 0 = channel 0, 1 = channel 1.
- out0_valid  output  1  channel 0 head item is valid.
- out0_ready  input  1  channel 0 consumer takes the head item.
- out0_kv  output  kv_t  channel 0 head item.
- out1_valid  output  1  channel 1 head item is valid.
- out1_ready  input  1  channel 1 consumer takes the head item.
- out1_kv  output  kv_t  channel 1 head item.
- out0_count  output  CW  channel 0 occupancy, range 0..DEPTH.
- out1_count  output  CW  channel 1 occupancy, range 0..DEPTH.

Behaviour:
- Reset (asynchronous, active-high):
  - Both FIFOs empty; read/write pointers = 0.
  - outN_valid = 0, outN_count = 0.
  - Storage cleared, so outN_kv = '0 while reset is held and immediately after.
  - Reset asserted mid-transfer discards all stored items; no partial state survives.
- Per channel N: an independent circular FIFO with rd_ptr, wr_ptr (log2(DEPTH) bits, wrap modulo DEPTH) and a count register.
- in_ready: combinational, = !flush && (count of channel in_sel < DEPTH). It depends on in_sel by design; the producer holds in_sel stable while in_valid is high.
- Accept: in_valid && in_ready at a rising edge.
  - in_kv is written at wr_ptr of channel in_sel; that wr_ptr increments.
  - The other channel is untouched.
- Output side:
  - outN_valid = (countN != 0).
  - outN_kv = storage[rd_ptrN], driven combinationally from registers.
  - Pop on outN_valid && outN_ready; rd_ptrN increments.
- Latency: an item accepted at edge k is visible on outN_kv/outN_valid in the cycle after edge k. There is no combinational in-to-out bypass.
- Ordering: FIFO order is kept within each channel. No ordering is guaranteed between channels.
- Simultaneous push and pop on the same channel: allowed whenever the push is accepted; countN is unchanged and both pointers advance.
- Full channel: not ready, even if a pop occurs in the same cycle. The freed slot is usable from the next cycle.
- Backpressure on one channel never deasserts in_ready for items destined to the other channel.
- outN_ready asserted while outN_valid = 0 has no effect.
- in_kv is ignored when in_valid = 0.
- flush (synchronous):
  - At the next edge both FIFOs become empty and pointers return to 0.
  - in_ready = 0 during the flush cycle, so no push occurs.
  - Pops in the flush cycle are discarded along with the rest of the contents.
  - rst has priority over flush.
- Counts: outN_count is the registered occupancy, updated +1 on push, -1 on pop, 0 on flush. It never exceeds DEPTH and never underflows.

Test Plan:
- Reset then route: after rst, push {key=5,val=0x12} with sel=0 → next cycle out0_valid=1, out0_kv={5,0x12}, out0_count=1; out1_valid=0 and out1_count=0 throughout.
- Fill and wrap (DEPTH=2), out0_ready=0:
  - Push keys 1, 2 to ch0 → out0_count=2 and in_ready=0 for sel=0, while in_ready=1 for sel=1.
  - Push key 9 to ch1 → accepted.
  - Pop one from ch0, then push key 3 to ch0; drain → ch0 yields 1, 2, 3 in order (pointer wrap).
- Simultaneous push/pop on ch1 at count=1: push key 7 with out1_ready=1 → count stays 1, key 7 is next at the head, no item is lost.
- Full-plus-pop: ch0 full (count=2) with out0_ready=1 and push to ch0 → in_ready=0, count drops to 1, key not stored; the next cycle the push is accepted.
- Flush: both channels hold 2 items; assert flush for 1 cycle with pushes pending → both counts=0, both valids=0 and in_ready=0 during that cycle; the following push is accepted normally.
- Async reset mid-stream: assert rst between clock edges while items are stored → valids, counts and outN_kv go to 0 immediately, without waiting for a clock edge; normal operation resumes after deassertion.

Source files
------------

// File: rtl/ra_pq_kv_demux.sv
// Buffered 1-to-2 kv steering block.
// Each output channel has its own FIFO so one stalled bank never blocks the other.
package pq_pkg;
  typedef struct packed {
    logic [7:0]  key;
    logic [15:0] val;
  } kv_t;
endpackage

module ra_pq_kv_demux
  import pq_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  kv_t           in_kv,
  input  logic          in_sel,
  output logic          out0_valid,
  input  logic          out0_ready,
  output kv_t           out0_kv,
  output logic          out1_valid,
  input  logic          out1_ready,
  output kv_t           out1_kv,
  output logic [CW-1:0] out0_count,
  output logic [CW-1:0] out1_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] rp  [2];
  logic [PW-1:0] wp  [2];
  logic [CW-1:0] cnt [2];
  kv_t           mem [2][DEPTH];
  logic [1:0]    push;
  logic [1:0]    pop;

  // A full channel refuses even if it pops this cycle.
  always_comb begin
    in_ready = !flush && (cnt[in_sel] != FULL);
    push = '0;
    push[in_sel] = in_valid && in_ready;
    pop[0] = (cnt[0] != '0) && out0_ready;
    pop[1] = (cnt[1] != '0) && out1_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        rp[c]  <= '0;
        wp[c]  <= '0;
        cnt[c] <= '0;
        for (int i = 0; i < DEPTH; i++)
          mem[c][i] <= '0;
      end
    end else if (flush) begin
      for (int c = 0; c < 2; c++) begin
        rp[c]  <= '0;
        wp[c]  <= '0;
        cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem[c][wp[c]] <= in_kv;
          wp[c] <= wp[c] + 1'b1;
        end
        if (pop[c])
          rp[c] <= rp[c] + 1'b1;
        unique case ({push[c], pop[c]})
          2'b10:   cnt[c] <= cnt[c] + 1'b1;
          2'b01:   cnt[c] <= cnt[c] - 1'b1;
          default: cnt[c] <= cnt[c];
        endcase
      end
    end
  end

  assign out0_valid = (cnt[0] != '0);
  assign out1_valid = (cnt[1] != '0);
  assign out0_kv    = mem[0][rp[0]];
  assign out1_kv    = mem[1][rp[1]];
  assign out0_count = cnt[0];
  assign out1_count = cnt[1];

endmodule

// File: tb/tb_ra_pq_kv_demux.sv
// Directed bench for ra_pq_kv_demux.
// Queue scoreboard per channel, checked with immediate assertions.
module tb_ra_pq_kv_demux;
  import pq_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk, rst, flush;
  logic in_valid, in_ready, in_sel;
  kv_t  in_kv;
  logic out0_valid, out0_ready, out1_valid, out1_ready;
  kv_t  out0_kv, out1_kv;
  logic [CW-1:0] out0_count, out1_count;

  int nchk = 0;
  int nfail = 0;
  kv_t q0[$];
  kv_t q1[$];

  ra_pq_kv_demux #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kv(in_kv), .in_sel(in_sel),
    .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out0_kv(out0_kv),
    .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out1_kv(out1_kv),
    .out0_count(out0_count), .out1_count(out1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic kv_t mk(input int k, input int v);
    kv_t r;
    r.key = 8'(k);
    r.val = 16'(v);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs();
    chk("v0", 32'(out0_valid), 32'(q0.size() != 0));
    chk("v1", 32'(out1_valid), 32'(q1.size() != 0));
    chk("c0", 32'(out0_count), 32'(q0.size()));
    chk("c1", 32'(out1_count), 32'(q1.size()));
    if (q0.size() != 0) chk("kv0", 32'(out0_kv), 32'(q0[0]));
    if (q1.size() != 0) chk("kv1", 32'(out1_kv), 32'(q1[0]));
  endtask

  // One clock cycle: drive, check at negedge, update model at posedge.
  task automatic cyc(input logic v, input logic sel, input kv_t kv,
                     input logic r0, input logic r1, input logic fl);
    logic erdy, acc;
    in_valid = v;
    in_sel = sel;
    in_kv = kv;
    out0_ready = r0;
    out1_ready = r1;
    flush = fl;
    @(negedge clk);
    erdy = !fl && ((sel ? q1.size() : q0.size()) < DEPTH);
    acc = v && erdy;
    chk("in_ready", 32'(in_ready), 32'(erdy));
    chk_outs();
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    @(posedge clk);
    if (fl) begin
      q0.delete();
      q1.delete();
    end else if (acc) begin
      if (sel) q1.push_back(kv);
      else q0.push_back(kv);
    end
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v0"}, 32'(out0_valid), 32'd0);
    chk({tag, "_v1"}, 32'(out1_valid), 32'd0);
    chk({tag, "_c0"}, 32'(out0_count), 32'd0);
    chk({tag, "_c1"}, 32'(out1_count), 32'd0);
    chk({tag, "_kv0"}, 32'(out0_kv), 32'd0);
    chk({tag, "_kv1"}, 32'(out1_kv), 32'd0);
  endtask

  initial begin
    kv_t z;
    z = '0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_sel = 1'b0;
    in_kv = mk(8'hAA, 16'hBEEF);
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #12;
    chk_zero("rst");
    @(posedge clk);
    #1 rst = 1'b0;

    // reset then route
    cyc(1, 0, mk(5, 'h12), 0, 0, 0);
    cyc(0, 0, z, 0, 0, 0);
    chk("route_kv0", 32'(out0_kv), 32'(mk(5, 'h12)));
    cyc(0, 0, z, 1, 0, 0);

    // fill and wrap
    cyc(1, 0, mk(1, 'h101), 0, 0, 0);
    cyc(1, 0, mk(2, 'h102), 0, 0, 0);
    cyc(1, 0, mk(8, 'h108), 0, 0, 0);
    cyc(0, 1, z, 0, 0, 0);
    cyc(1, 1, mk(9, 'h109), 0, 0, 0);
    cyc(0, 0, z, 1, 0, 0);
    cyc(1, 0, mk(3, 'h103), 0, 0, 0);
    cyc(0, 0, z, 1, 0, 0);
    cyc(0, 0, z, 1, 0, 0);
    cyc(0, 0, z, 1, 0, 0);

    // simultaneous push/pop on ch1 at count 1
    cyc(1, 1, mk(7, 'h107), 0, 1, 0);
    cyc(0, 1, z, 0, 0, 0);
    chk("pp_c1", 32'(out1_count), 32'd1);
    chk("pp_key", 32'(out1_kv.key), 32'd7);
    cyc(0, 1, z, 0, 1, 0);

    // full plus pop on ch0
    cyc(1, 0, mk(4, 'h104), 0, 0, 0);
    cyc(1, 0, mk(5, 'h105), 0, 0, 0);
    cyc(1, 0, mk(6, 'h106), 1, 0, 0);
    cyc(1, 0, mk(6, 'h106), 0, 0, 0);

    // flush with both channels full and pushes pending
    cyc(1, 1, mk(10, 'h10A), 0, 0, 0);
    cyc(1, 1, mk(11, 'h10B), 0, 0, 0);
    cyc(1, 0, mk(12, 'h10C), 1, 0, 1);
    chk("fl_c0", 32'(out0_count), 32'd0);
    chk("fl_c1", 32'(out1_count), 32'd0);
    cyc(1, 1, mk(13, 'h10D), 0, 0, 0);
    cyc(1, 0, mk(14, 'h10E), 0, 0, 0);

    // async reset between edges
    cyc(0, 0, z, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk_zero("arst");
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 1, mk(15, 'h10F), 0, 0, 0);
    cyc(1, 0, mk(16, 'h110), 0, 1, 0);
    cyc(0, 0, z, 1, 1, 0);
    cyc(0, 0, z, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
